// File: rtl/acq_sequencer.sv
// acq_sequencer: scans enabled mux channels, settles, converts, reads the ADC over SPI and streams tagged samples.
// Optional ACQ_OVERRANGE_EN adds sample_ovr and sticky per-channel ovr_chn_flags.
module acq_sequencer #(
   parameter int NUM_CHN       = 8,
   parameter int CHN_W         = 3,
   parameter int ADC_BITS      = 16,
   parameter int SCK_DIV       = 2,
   parameter int SETTLE_CYCLES = 16,
   parameter int CNV_CYCLES    = 2,
   parameter int BUSY_TIMEOUT  = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [NUM_CHN-1:0]  chn_mask,
   output logic                scan_active,
   output logic                scan_done,
   output logic                timeout_err,
   output logic                adc_cnv,
   input  logic                adc_busy,
   input  logic                adc_miso,
   output logic                adc_sck,
   output logic [CHN_W-1:0]    analog_mux_chn,
   output logic [ADC_BITS-1:0] sample_data,
   output logic [CHN_W-1:0]    sample_chn,
   output logic                sample_valid,
   input  logic                sample_ready
`ifdef ACQ_OVERRANGE_EN
   ,
   output logic                sample_ovr,
   output logic [NUM_CHN-1:0]  ovr_chn_flags
`endif
);
   localparam int CNT_W = 16;
   localparam int BIT_W = $clog2(ADC_BITS);
   typedef enum logic [2:0] {IDLE, SETTLE, CONVERT, WAIT_BUSY, READ, OUTPUT, NEXT, DONE} state_t;
   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic                sck_q, sck_d;
   logic [NUM_CHN-1:0]  mask_q, mask_d;
   logic [CHN_W-1:0]    chn_q, chn_d;
   logic [ADC_BITS-1:0] data_q, data_d;
   logic                terr_q, terr_d;
   logic [CHN_W:0]      fst, nxt;
   // Lowest enabled channel at or above lo; MSB flags that one exists.
   function automatic logic [CHN_W:0] first_from(input logic [NUM_CHN-1:0] m, input int lo);
      logic [CHN_W:0] r;
      r = '0;
      for (int i = NUM_CHN - 1; i >= 0; i--)
         if (m[i] && i >= lo) r = {1'b1, CHN_W'(i)};
      return r;
   endfunction
   assign fst = first_from(chn_mask, 0);
   assign nxt = first_from(mask_q, int'(chn_q) + 1);
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sck_d   = sck_q;
      mask_d  = mask_q;
      chn_d   = chn_q;
      data_d  = data_q;
      terr_d  = terr_q;
      case (state_q)
         IDLE: if (start) begin
            mask_d  = chn_mask;
            terr_d  = 1'b0;
            cnt_d   = '0;
            chn_d   = fst[CHN_W] ? fst[CHN_W-1:0] : chn_q;
            state_d = fst[CHN_W] ? SETTLE : DONE;
         end
         SETTLE: begin
            cnt_d   = (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) ? '0 : cnt_q + CNT_W'(1);
            state_d = (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) ? CONVERT : SETTLE;
         end
         CONVERT: begin
            cnt_d   = (cnt_q == CNT_W'(CNV_CYCLES - 1)) ? '0 : cnt_q + CNT_W'(1);
            state_d = (cnt_q == CNT_W'(CNV_CYCLES - 1)) ? WAIT_BUSY : CONVERT;
         end
         WAIT_BUSY: begin
            cnt_d = cnt_q + CNT_W'(1);
            // busy is not yet valid on the first cycle after the conversion pulse
            if (cnt_q != '0 && !adc_busy) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = READ;
            end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
               cnt_d   = '0;
               terr_d  = 1'b1;
               data_d  = '0;
               state_d = OUTPUT;
            end
         end
         READ: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(SCK_DIV - 1)) begin
               cnt_d = '0;
               sck_d = !sck_q;
               if (!sck_q) data_d = {data_q[ADC_BITS-2:0], adc_miso};
               else if (bit_q == BIT_W'(ADC_BITS - 1)) state_d = OUTPUT;
               else bit_d = bit_q + BIT_W'(1);
            end
         end
         OUTPUT: state_d = sample_ready ? NEXT : OUTPUT;
         NEXT: begin
            cnt_d   = '0;
            chn_d   = nxt[CHN_W] ? nxt[CHN_W-1:0] : chn_q;
            state_d = nxt[CHN_W] ? SETTLE : DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sck_q   <= 1'b0;
         mask_q  <= '0;
         chn_q   <= '0;
         data_q  <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sck_q   <= sck_d;
         mask_q  <= mask_d;
         chn_q   <= chn_d;
         data_q  <= data_d;
         terr_q  <= terr_d;
      end
   end
   assign scan_active    = state_q != IDLE;
   assign scan_done      = state_q == DONE;
   assign timeout_err    = terr_q;
   assign adc_cnv        = state_q == CONVERT;
   assign adc_sck        = sck_q;
   assign analog_mux_chn = chn_q;
   assign sample_data    = data_q;
   assign sample_chn     = chn_q;
   assign sample_valid   = state_q == OUTPUT;
`ifdef ACQ_OVERRANGE_EN
   logic [NUM_CHN-1:0] flags_q, flags_d;
   // A timed-out sample reads as zero, so the all-zeros test also covers timeouts.
   assign sample_ovr    = sample_valid & (&data_q | ~|data_q);
   assign flags_d       = (state_q == IDLE && start) ? '0 : flags_q | ({{(NUM_CHN-1){1'b0}}, sample_ovr} << chn_q);
   assign ovr_chn_flags = flags_q;
   always_ff @(posedge clk) flags_q <= rst ? '0 : flags_d;
`endif
endmodule

// File: tb/tb_acq_sequencer.sv
// tb_acq_sequencer: directed scans against an ADC/SPI model with a sample scoreboard.
module tb_acq_sequencer;
   logic        clk = 1'b0;
   logic        rst, start, adc_busy, adc_miso, adc_cnv, adc_sck, sample_ready;
   logic        scan_active, scan_done, timeout_err, sample_valid;
   logic [7:0]  chn_mask;
   logic [2:0]  analog_mux_chn, sample_chn;
   logic [15:0] sample_data;
`ifdef ACQ_OVERRANGE_EN
   logic        sample_ovr;
   logic [7:0]  ovr_chn_flags;
`endif
   typedef struct packed {logic [2:0] chn; logic [15:0] data; logic ovr;} exp_t;
   exp_t        q[$];
   int          checks = 0, errors = 0, n_samples = 0, done_cnt = 0, act_cnt = 0;
   logic [15:0] word [8];
   logic        stuck = 1'b0, sck_prev = 1'b0;
   int          bcnt = 0, rc = 16;
   logic [15:0] cur;
   logic [2:0]  prev_mux = '0;

   acq_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .chn_mask(chn_mask),
      .scan_active(scan_active), .scan_done(scan_done), .timeout_err(timeout_err),
      .adc_cnv(adc_cnv), .adc_busy(adc_busy), .adc_miso(adc_miso), .adc_sck(adc_sck),
      .analog_mux_chn(analog_mux_chn), .sample_data(sample_data), .sample_chn(sample_chn),
      .sample_valid(sample_valid), .sample_ready(sample_ready)
`ifdef ACQ_OVERRANGE_EN
      , .sample_ovr(sample_ovr), .ovr_chn_flags(ovr_chn_flags)
`endif
   );

   always #5 clk = ~clk;

   // ADC model: busy follows the conversion pulse, MISO shifts MSB first on each SCK rise
   assign adc_busy = stuck || bcnt != 0;
   assign cur      = word[analog_mux_chn];
   assign adc_miso = (rc < 16) ? cur[4'(15 - rc)] : 1'b0;
   always @(posedge clk) begin
      if (adc_cnv) begin
         bcnt <= 6;
         rc   <= 0;
      end else begin
         if (bcnt != 0) bcnt <= bcnt - 1;
         if (adc_sck && !sck_prev) rc <= rc + 1;
      end
      sck_prev <= adc_sck;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic push(input logic [2:0] c, input logic [15:0] d);
      q.push_back({c, d, (d == 16'h0000 || d == 16'hFFFF)});
   endtask

   task automatic pulse(input logic [7:0] m);
      @(negedge clk);
      chn_mask = m;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      for (int i = 0; i < budget && !scan_done; i++) @(negedge clk);
      chk(tag, 32'(scan_done), 32'd1);
      @(negedge clk);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_ctl"}, 32'({scan_active, scan_done, timeout_err, adc_cnv, adc_sck, sample_valid,
                              analog_mux_chn, sample_chn}), 32'd0);
      chk({tag, "_data"}, 32'(sample_data), 32'd0);
   endtask

   // scoreboard collector and activity monitors, sampled mid-low-phase
   always begin
      @(negedge clk);
      #1;
      if (scan_done) done_cnt++;
      if (adc_cnv || adc_sck || sample_valid) act_cnt++;
      if (!rst && (adc_cnv || adc_sck)) chk("mux_stable", 32'(analog_mux_chn), 32'(prev_mux));
      prev_mux = analog_mux_chn;
      if (!rst && sample_valid && sample_ready) begin
         chk("sb_pending", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("sb_chn", 32'(sample_chn), 32'(e.chn));
            chk("sb_data", 32'(sample_data), 32'(e.data));
`ifdef ACQ_OVERRANGE_EN
            chk("sb_ovr", 32'(sample_ovr), 32'(e.ovr));
`endif
         end
         n_samples++;
      end
   end

   initial begin
      int d0, s0, a0, n;
      logic ok;
      logic [15:0] cap_d;
      logic [2:0]  cap_c;
      rst = 1'b1; start = 1'b0; chn_mask = '0; sample_ready = 1'b1;
      for (int i = 0; i < 8; i++) word[i] = 16'hA5C3;
      repeat (3) @(negedge clk);
      chk_idle("reset");
      rst = 1'b0;

      // three-channel scan
      push(3'd2, 16'hA5C3); push(3'd5, 16'hA5C3); push(3'd7, 16'hA5C3);
      d0 = done_cnt; s0 = n_samples;
      pulse(8'b1010_0100);
      chk("a_active", 32'(scan_active), 32'd1);
      chk("a_first_mux", 32'(analog_mux_chn), 32'd2);
      wait_done("a_done_seen", 3000);
      chk("a_samples", 32'(n_samples - s0), 32'd3);
      chk("a_done_pulses", 32'(done_cnt - d0), 32'd1);
      chk("a_done_clear", 32'(scan_done), 32'd0);
      chk("a_inactive", 32'(scan_active), 32'd0);

      // empty mask
      a0 = act_cnt; d0 = done_cnt; s0 = n_samples;
      pulse(8'h00);
      chk("z_done", 32'(scan_done), 32'd1);
      @(negedge clk);
      chk("z_done_clear", 32'(scan_done), 32'd0);
      @(negedge clk);
      chk("z_activity", 32'(act_cnt - a0), 32'd0);
      chk("z_samples", 32'(n_samples - s0), 32'd0);
      chk("z_done_pulses", 32'(done_cnt - d0), 32'd1);

      // backpressure on the first sample
      word[3] = 16'h1234; word[4] = 16'hBEEF;
      sample_ready = 1'b0;
      push(3'd3, 16'h1234); push(3'd4, 16'hBEEF);
      pulse(8'b0001_1000);
      for (int i = 0; i < 2000 && !sample_valid; i++) @(negedge clk);
      chk("hold_valid_seen", 32'(sample_valid), 32'd1);
      cap_d = sample_data; cap_c = sample_chn; ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         ok &= sample_valid && sample_data == cap_d && sample_chn == cap_c && analog_mux_chn == cap_c;
      end
      chk("hold_stable", 32'(ok), 32'd1);
      chk("hold_data", 32'(sample_data), 32'h1234);
      chk("hold_chn", 32'(sample_chn), 32'd3);
      sample_ready = 1'b1;
      wait_done("hold_done_seen", 3000);

      // ADC busy stuck high
      stuck = 1'b1;
      push(3'd0, 16'h0000); push(3'd1, 16'h0000);
      pulse(8'b0000_0011);
      for (int i = 0; i < 200 && !adc_cnv; i++) @(negedge clk);
      for (int i = 0; i < 20 && adc_cnv; i++) @(negedge clk);
      n = 0;
      while (!timeout_err && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("to_cycles", 32'(n), 32'd255);
      wait_done("to_done_seen", 3000);
      stuck = 1'b0;
      chk("to_sticky", 32'(timeout_err), 32'd1);
`ifdef ACQ_OVERRANGE_EN
      chk("to_flags", 32'(ovr_chn_flags), 32'h03);
`endif
      pulse(8'h00);
      chk("to_cleared", 32'(timeout_err), 32'd0);
      @(negedge clk);

      // reset during readout of channel 3
      word[1] = 16'h1111; word[3] = 16'h3333;
      push(3'd1, 16'h1111);
      pulse(8'b0000_1010);
      for (int i = 0; i < 2000 && !(analog_mux_chn == 3'd3 && adc_sck); i++) @(negedge clk);
      chk("rr_in_read", 32'(analog_mux_chn == 3'd3 && adc_sck), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk_idle("rr_reset");
      rst = 1'b0;
      push(3'd1, 16'h1111); push(3'd3, 16'h3333);
      pulse(8'b0000_1010);
      chk("rr_restart_mux", 32'(analog_mux_chn), 32'd1);
      wait_done("rr_done_seen", 3000);

      // overrange pattern
      word[0] = 16'h1234; word[1] = 16'hFFFF;
      push(3'd0, 16'h1234); push(3'd1, 16'hFFFF);
      pulse(8'b0000_0011);
      wait_done("ovr_done_seen", 3000);
`ifdef ACQ_OVERRANGE_EN
      chk("ovr_flags", 32'(ovr_chn_flags), 32'h02);
`endif
      repeat (2) @(negedge clk);
      chk("sb_empty", 32'(q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
